// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
package seg_scan_ctrl_pkg;
    localparam int         DIGITS_MAX = 8;
    localparam logic [6:0] SEG_OFF    = 7'b000_0000;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-word update port: valid/ready handshake carrying the packed digits and dp enables.
interface seg_scan_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  upd_valid;
    logic                  upd_ready;
    logic [4*DIGITS-1:0]   upd_value;
    logic [DIGITS-1:0]     upd_dp;

    modport master (output upd_valid, output upd_value, output upd_dp, input  upd_ready);
    modport slave  (input  upd_valid, input  upd_value, input  upd_dp, output upd_ready);
endinterface

// File: rtl/seg_scan_ctrl_bcd7.sv
// BCD7 hex-to-segment decoder; output bits are {g,f,e,d,c,b,a}, active-high.
module seg_scan_ctrl_bcd7 (
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);
    always_comb begin
        seg_o = 7'b000_0000;
        unique case (nib_i)
            4'h0: seg_o = 7'b011_1111;
            4'h1: seg_o = 7'b000_0110;
            4'h2: seg_o = 7'b101_1011;
            4'h3: seg_o = 7'b100_1111;
            4'h4: seg_o = 7'b110_0110;
            4'h5: seg_o = 7'b110_1101;
            4'h6: seg_o = 7'b111_1101;
            4'h7: seg_o = 7'b000_0111;
            4'h8: seg_o = 7'b111_1111;
            4'h9: seg_o = 7'b110_1111;
            4'hA: seg_o = 7'b111_0111;
            4'hB: seg_o = 7'b111_1100;
            4'hC: seg_o = 7'b011_1001;
            4'hD: seg_o = 7'b101_1110;
            4'hE: seg_o = 7'b111_1001;
            4'hF: seg_o = 7'b111_0001;
            default: seg_o = 7'b000_0000;
        endcase
    end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a double-buffered, tear-free display word.
// Define SEG_SCAN_LZB_EN to blank leading zero digits (digit 0 is always shown).
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic               clk,
    input  logic               rst_n,
    seg_scan_ctrl_if.slave     upd,
    output logic [6:0]         seg,
    output logic               dp,
    output logic [DIGITS-1:0]  an_n,
    output logic               frame_tick
);
    localparam int          CNT_W  = $clog2(SCAN_DIV);
    localparam int          IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam scan_state_e ST_RST = (BLANK_CYC > 0) ? BLANK : SHOW;

    logic [DIGITS-1:0][3:0] pend_val_q, act_val_q;
    logic [DIGITS-1:0]      pend_dp_q, act_dp_q;
    logic                   pend_flag_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    scan_state_e            state_q, state_d;

    logic [6:0]             seg_q, seg_d;
    logic                   dp_q, dp_d;
    logic [DIGITS-1:0]      an_n_q, an_n_d;

    logic                   cnt_last, idx_last, frame_end, xfer;
    logic [3:0]             dig_nib;
    logic [6:0]             dig_seg;
    logic [DIGITS-1:0]      lz_blank;

    assign cnt_last   = (cnt_q == CNT_W'(SCAN_DIV - 1));
    assign idx_last   = (idx_q == IDX_W'(DIGITS - 1));
    assign frame_end  = cnt_last && idx_last;
    assign xfer       = upd.upd_valid && !pend_flag_q;

    assign upd.upd_ready = !pend_flag_q;
    assign frame_tick    = frame_end;
    assign seg           = seg_q;
    assign dp            = dp_q;
    assign an_n          = an_n_q;

    // Slot counter and digit index
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_last) begin
            cnt_d = '0;
            idx_d = idx_last ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // Pending buffer fills only when empty; it drains into the active word at frame end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val_q  <= '0;
            pend_dp_q   <= '0;
            pend_flag_q <= 1'b0;
            act_val_q   <= '0;
            act_dp_q    <= '0;
        end else begin
            if (xfer) begin
                pend_val_q  <= upd.upd_value;
                pend_dp_q   <= upd.upd_dp;
                pend_flag_q <= 1'b1;
            end else if (frame_end && pend_flag_q) begin
                act_val_q   <= pend_val_q;
                act_dp_q    <= pend_dp_q;
                pend_flag_q <= 1'b0;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_RST;
        else        state_q <= state_d;
    end

    // FSM: next state tracks whether the upcoming slot position is inside the blank window
    always_comb begin
        state_d = (int'(cnt_d) < BLANK_CYC) ? BLANK : SHOW;
    end

`ifdef SEG_SCAN_LZB_EN
    logic lz_run;
    always_comb begin
        lz_blank = '0;
        lz_run   = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            lz_run      = lz_run && (act_val_q[k] == 4'h0);
            lz_blank[k] = lz_run;
        end
    end
`else
    assign lz_blank = '0;
`endif

    assign dig_nib = act_val_q[idx_q];

    seg_scan_ctrl_bcd7 u_bcd7 (
        .nib_i (dig_nib),
        .seg_o (dig_seg)
    );

    // FSM: outputs, registered below so the pins lag the scan position by one cycle
    always_comb begin
        seg_d  = SEG_OFF;
        dp_d   = 1'b0;
        an_n_d = '1;
        if (state_q == SHOW) begin
            an_n_d[idx_q] = 1'b0;
            dp_d          = act_dp_q[idx_q];
            seg_d         = lz_blank[idx_q] ? SEG_OFF : dig_seg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q  <= SEG_OFF;
            dp_q   <= 1'b0;
            an_n_q <= '1;
        end else begin
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            an_n_q <= an_n_d;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
// n counts rising edges since reset release; pins at n reflect the scan position n-1.
module tb_seg_scan_ctrl;
    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;
`ifdef SEG_SCAN_LZB_EN
    localparam logic [6:0] LZ0 = 7'b000_0000;
`else
    localparam logic [6:0] LZ0 = 7'b011_1111;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [6:0]        seg;
    logic              dp;
    logic [DIGITS-1:0] an_n;
    logic              frame_tick;

    int checks = 0;
    int errors = 0;
    int n = 0;

    seg_scan_ctrl_if #(.DIGITS(DIGITS)) u_if ();

    seg_scan_ctrl #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .upd        (u_if),
        .seg        (seg),
        .dp         (dp),
        .an_n       (an_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    task automatic adv_to(input int target);
        while (n < target) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic chk_pins(input string tag, input logic [3:0] an_e,
                            input logic [6:0] seg_e, input logic dp_e);
        chk({tag, ".an_n"}, 32'(an_n), 32'(an_e));
        chk({tag, ".seg"},  32'(seg),  32'(seg_e));
        chk({tag, ".dp"},   32'(dp),   32'(dp_e));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        u_if.upd_valid = 1'b0;
        u_if.upd_value = '0;
        u_if.upd_dp    = '0;
        repeat (3) @(negedge clk);
        chk_pins("rst", 4'b1111, 7'b000_0000, 1'b0);
        chk("rst.tick",  32'(frame_tick),     32'd0);
        chk("rst.ready", 32'(u_if.upd_ready), 32'd1);

        rst_n = 1'b1;
        n = 0;
        adv_to(1);
        chk_pins("f0.blank", 4'b1111, 7'b000_0000, 1'b0);
        adv_to(3);
        chk_pins("f0.d0", 4'b1110, 7'b011_1111, 1'b0);

        // First update mid-frame, then a second offer held while the buffer is full
        adv_to(10);
        u_if.upd_valid = 1'b1;
        u_if.upd_value = 16'h1234;
        u_if.upd_dp    = 4'b0100;
        adv_to(11);
        chk("upd1.ready_lo", 32'(u_if.upd_ready), 32'd0);
        u_if.upd_value = 16'h5678;
        u_if.upd_dp    = 4'b0001;
        adv_to(30);
        chk("f0.tick30", 32'(frame_tick), 32'd0);
        adv_to(31);
        chk("f0.tick31", 32'(frame_tick), 32'd1);
        chk("f0.ready31", 32'(u_if.upd_ready), 32'd0);
        adv_to(32);
        chk("commit1.ready", 32'(u_if.upd_ready), 32'd1);
        adv_to(33);
        chk("upd2.accepted", 32'(u_if.upd_ready), 32'd0);
        u_if.upd_valid = 1'b0;

        adv_to(34);
        chk_pins("f1.blank", 4'b1111, 7'b000_0000, 1'b0);
        adv_to(35);
        chk_pins("f1.d0", 4'b1110, 7'b110_0110, 1'b0);
        adv_to(41);
        chk_pins("f1.gap", 4'b1111, 7'b000_0000, 1'b0);
        adv_to(43);
        chk_pins("f1.d1", 4'b1101, 7'b100_1111, 1'b0);
        adv_to(51);
        chk_pins("f1.d2", 4'b1011, 7'b101_1011, 1'b1);
        adv_to(59);
        chk_pins("f1.d3", 4'b0111, 7'b000_0110, 1'b0);
        adv_to(63);
        chk("f1.ready63", 32'(u_if.upd_ready), 32'd0);
        chk("f1.tick63",  32'(frame_tick),     32'd1);
        adv_to(64);
        chk("commit2.ready", 32'(u_if.upd_ready), 32'd1);
        adv_to(67);
        chk_pins("f2.d0", 4'b1110, 7'b111_1111, 1'b1);

        // Transfer on the frame-end cycle lands in pending and waits a full frame
        adv_to(95);
        chk("f2.tick95",  32'(frame_tick),     32'd1);
        chk("f2.ready95", 32'(u_if.upd_ready), 32'd1);
        u_if.upd_valid = 1'b1;
        u_if.upd_value = 16'h0070;
        u_if.upd_dp    = 4'b0000;
        adv_to(96);
        u_if.upd_valid = 1'b0;
        chk("fe.ready96", 32'(u_if.upd_ready), 32'd0);
        adv_to(99);
        chk_pins("f3.d0_old", 4'b1110, 7'b111_1111, 1'b1);
        adv_to(127);
        chk("f3.ready127", 32'(u_if.upd_ready), 32'd0);
        adv_to(128);
        chk("commit3.ready", 32'(u_if.upd_ready), 32'd1);
        adv_to(131);
        chk_pins("f4.d0", 4'b1110, 7'b011_1111, 1'b0);
        adv_to(139);
        chk_pins("f4.d1", 4'b1101, 7'b000_0111, 1'b0);

        // Queue a word, then reset during digit 2's SHOW window
        adv_to(140);
        u_if.upd_valid = 1'b1;
        u_if.upd_value = 16'h9999;
        u_if.upd_dp    = 4'b1111;
        adv_to(141);
        u_if.upd_valid = 1'b0;
        chk("pend9.ready", 32'(u_if.upd_ready), 32'd0);
        adv_to(147);
        chk_pins("f4.d2", 4'b1011, LZ0, 1'b0);
        adv_to(148);
        chk("f4.d2_show", 32'(an_n), 32'(4'b1011));
        #1 rst_n = 1'b0;
        #1;
        chk_pins("arst", 4'b1111, 7'b000_0000, 1'b0);
        chk("arst.ready", 32'(u_if.upd_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;

        adv_to(3);
        chk_pins("r.d0", 4'b1110, 7'b011_1111, 1'b0);
        adv_to(27);
        chk_pins("r.d3", 4'b0111, LZ0, 1'b0);
        adv_to(31);
        chk("r.tick31", 32'(frame_tick), 32'd1);
        adv_to(35);
        chk_pins("r.d0_nolost", 4'b1110, 7'b011_1111, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
